tcp_pkt_buffer: RTL and testbench

//  Packet-mode FIFO for the TCP datapath, one clock domain, valid/ready on both sides.

---
 rtl/tcp_pkt_buffer.sv | 190 +++++++++++++++++++
 tb/tb_tcp_pkt_buffer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_pkt_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tcp_pkt_buffer
//  Purpose  : Packet-mode FIFO between the RX parser and the TCP engine.
//             Words of a packet are staged speculatively and become readable
//             only when in_last commits them.
//             A packet is discarded on in_drop or when it overflows the
//             storage without any committed data to drain.
//  Ports    : clk, resetn               - clock, async active-low reset
//             in_valid/in_ready/in_data/in_last/in_drop - write side
//             out_valid/out_ready/out_data/out_last     - read side (registered)
//             used_words, pkt_count, almost_full        - occupancy status
//             ovf_err, drop_cnt                         - drop reporting
//  Revision : 1.0 - initial release
// ============================================================================
module tcp_pkt_buffer #(
   parameter int DATA_BITS    = 512,
   parameter int ADDR_BITS    = 10,
   parameter int MEM_DEPTH    = 1 << ADDR_BITS,
   parameter int AFULL_THRESH = MEM_DEPTH - 16
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_BITS-1:0] in_data,
   input  logic                 in_last,
   input  logic                 in_drop,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_BITS-1:0] out_data,
   output logic                 out_last,
   output logic [ADDR_BITS:0]   used_words,
   output logic [ADDR_BITS:0]   pkt_count,
   output logic                 almost_full,
   output logic                 ovf_err,
   output logic [15:0]          drop_cnt
);

   localparam logic [ADDR_BITS:0] c_depth = (ADDR_BITS+1)'(MEM_DEPTH);
   localparam logic [ADDR_BITS:0] c_afull = (ADDR_BITS+1)'(AFULL_THRESH);
   localparam logic [ADDR_BITS:0] c_one   = (ADDR_BITS+1)'(1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PKT     = 2'd1,
      S_DISCARD = 2'd2
   } state_t;

   // Storage: payload plus the packet-end flag in the top bit.
   logic [DATA_BITS:0]   r_mem [MEM_DEPTH];

   state_t               r_state;
   logic [ADDR_BITS:0]   r_wr_ptr;
   logic [ADDR_BITS:0]   r_commit_ptr;
   logic [ADDR_BITS:0]   r_rd_ptr;
   logic [ADDR_BITS:0]   r_pkt_count;
   logic [15:0]          r_drop_cnt;
   logic                 r_in_ready;
   logic                 r_out_valid;
   logic [DATA_BITS-1:0] r_out_data;
   logic                 r_out_last;
   logic                 r_ovf_err;

   logic                 w_full;
   logic                 w_in_fire;
   logic                 w_drop;
   logic                 w_ovf;
   logic                 w_store;
   logic                 w_commit;
   logic                 w_discard_end;
   logic                 w_discard_nxt;
   logic                 w_rd_fire;
   logic                 w_consume_last;
   logic [ADDR_BITS:0]   w_wr_ptr_nxt;
   logic [ADDR_BITS:0]   w_rd_ptr_nxt;
   logic [ADDR_BITS:0]   w_used;
   logic [ADDR_BITS:0]   w_used_nxt;
   logic [DATA_BITS:0]   w_rd_word;

   assign w_used    = r_wr_ptr - r_rd_ptr;
   assign w_full    = (w_used == c_depth);
   assign w_in_fire = in_valid && r_in_ready;

   // A drop outranks any write in the same cycle; it is ignored while sinking.
   assign w_drop        = in_drop && (r_state != S_DISCARD);
   // Every stored word is still staged, so waiting for reads can never free
   // space for this packet: abandon it and sink the rest.
   assign w_ovf         = !w_drop && (r_state == S_PKT) && w_full &&
                          (r_commit_ptr == r_rd_ptr);
   assign w_store       = w_in_fire && !w_drop && !w_ovf && (r_state != S_DISCARD);
   assign w_commit      = w_store && in_last;
   assign w_discard_end = (r_state == S_DISCARD) && w_in_fire && in_last;
   assign w_discard_nxt = w_ovf || ((r_state == S_DISCARD) && !w_discard_end);

   // Only committed words are read, and those were written on an earlier edge.
   assign w_rd_fire      = (!r_out_valid || out_ready) && (r_commit_ptr != r_rd_ptr);
   assign w_consume_last = r_out_valid && out_ready && r_out_last;
   assign w_rd_word      = r_mem[r_rd_ptr[ADDR_BITS-1:0]];

   assign w_wr_ptr_nxt = (w_drop || w_ovf) ? r_commit_ptr :
                         w_store           ? (r_wr_ptr + c_one) : r_wr_ptr;
   assign w_rd_ptr_nxt = w_rd_fire ? (r_rd_ptr + c_one) : r_rd_ptr;
   assign w_used_nxt   = w_wr_ptr_nxt - w_rd_ptr_nxt;

   always_ff @(posedge clk) begin
      if (w_store) begin
         r_mem[r_wr_ptr[ADDR_BITS-1:0]] <= {in_last, in_data};
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state      <= S_IDLE;
         r_wr_ptr     <= '0;
         r_commit_ptr <= '0;
         r_rd_ptr     <= '0;
         r_pkt_count  <= '0;
         r_drop_cnt   <= '0;
         r_in_ready   <= 1'b0;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_last   <= 1'b0;
         r_ovf_err    <= 1'b0;
      end else begin
         r_wr_ptr <= w_wr_ptr_nxt;
         r_rd_ptr <= w_rd_ptr_nxt;
         if (w_commit) begin
            r_commit_ptr <= r_wr_ptr + c_one;
         end

         case (r_state)
            S_IDLE: begin
               if (!w_drop && w_store && !in_last) begin
                  r_state <= S_PKT;
               end
            end
            S_PKT: begin
               if (w_drop) begin
                  r_state <= S_IDLE;
               end else if (w_ovf) begin
                  r_state <= S_DISCARD;
               end else if (w_commit) begin
                  r_state <= S_IDLE;
               end
            end
            S_DISCARD: begin
               if (w_discard_end) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         // in_ready is registered, so it is computed from next-cycle state.
         r_in_ready <= w_discard_nxt || (w_used_nxt != c_depth);
         r_ovf_err  <= w_ovf;

         if ((w_drop || w_ovf) && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
         end

         case ({w_commit, w_consume_last})
            2'b10:   r_pkt_count <= r_pkt_count + c_one;
            2'b01:   r_pkt_count <= r_pkt_count - c_one;
            default: r_pkt_count <= r_pkt_count;
         endcase

         if (w_rd_fire) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_rd_word[DATA_BITS-1:0];
            r_out_last  <= w_rd_word[DATA_BITS];
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign in_ready    = r_in_ready;
   assign out_valid   = r_out_valid;
   assign out_data    = r_out_data;
   assign out_last    = r_out_last;
   assign used_words  = w_used;
   assign pkt_count   = r_pkt_count;
   assign almost_full = (w_used >= c_afull);
   assign ovf_err     = r_ovf_err;
   assign drop_cnt    = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tcp_pkt_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tcp_pkt_buffer
//  Purpose  : Directed self-checking bench for tcp_pkt_buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tcp_pkt_buffer;

   localparam int DATA_BITS = 512;
   localparam int ADDR_BITS = 10;

   logic                 clk = 1'b0;
   logic                 resetn;
   logic                 in_valid;
   logic                 in_ready;
   logic [DATA_BITS-1:0] in_data;
   logic                 in_last;
   logic                 in_drop;
   logic                 out_valid;
   logic                 out_ready;
   logic [DATA_BITS-1:0] out_data;
   logic                 out_last;
   logic [ADDR_BITS:0]   used_words;
   logic [ADDR_BITS:0]   pkt_count;
   logic                 almost_full;
   logic                 ovf_err;
   logic [15:0]          drop_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Monitor state
   logic [32:0] q_got[$];
   bit          seen_valid;
   int          ovf_seen;
   bit          af_seen;
   int          af_used;

   tcp_pkt_buffer #(
      .DATA_BITS (DATA_BITS),
      .ADDR_BITS (ADDR_BITS)
   ) u_dut (
      .clk         (clk),
      .resetn      (resetn),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_last     (in_last),
      .in_drop     (in_drop),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_last    (out_last),
      .used_words  (used_words),
      .pkt_count   (pkt_count),
      .almost_full (almost_full),
      .ovf_err     (ovf_err),
      .drop_cnt    (drop_cnt)
   );

   always #5 clk = ~clk;

   // Inputs change 1 ns after posedge, so negedge sees the handshake that
   // the next posedge will perform.
   always @(negedge clk) begin
      if (resetn) begin
         if (out_valid && out_ready) q_got.push_back({out_last, out_data[31:0]});
         if (out_valid) seen_valid = 1'b1;
         if (ovf_err) ovf_seen++;
         if (almost_full && !af_seen) begin
            af_seen = 1'b1;
            af_used = int'(used_words);
         end
      end
   end

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [31:0] d, input logic last);
      int b;
      in_valid = 1'b1;
      in_data  = DATA_BITS'(d);
      in_last  = last;
      b = 0;
      while (!in_ready && b < 4000) begin
         tick();
         b++;
      end
      if (!in_ready) check("in_ready_timeout", in_ready, 1);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_words(input int n);
      int b;
      b = 0;
      while (q_got.size() < n && b < 5000) begin
         tick();
         b++;
      end
      check("rd_count", q_got.size(), n);
   endtask

   task automatic clear_mon();
      q_got.delete();
      seen_valid = 1'b0;
      ovf_seen   = 0;
      af_seen    = 1'b0;
      af_used    = 0;
   endtask

   initial begin
      int bad;
      logic [32:0] exp_w;

      resetn = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      in_drop = 1'b0; out_ready = 1'b0;
      clear_mon();

      // ---- 1: reset values, single-word packet ----
      repeat (3) tick();
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_used", used_words, 0);
      check("rst_pkt", pkt_count, 0);
      check("rst_drop", drop_cnt, 0);
      check("rst_out_data", out_data, 0);
      check("rst_misc", {out_last, almost_full, ovf_err}, 0);
      resetn = 1'b1;
      tick();
      check("t1_in_ready", in_ready, 1);
      send_word(32'hA5, 1'b1);
      check("t1_pkt_commit", pkt_count, 1);
      check("t1_valid_commit", out_valid, 0);
      tick();
      check("t1_valid", out_valid, 1);
      check("t1_data", out_data, 512'hA5);
      check("t1_last", out_last, 1);
      out_ready = 1'b1;
      tick();
      check("t1_pkt_after", pkt_count, 0);
      check("t1_valid_after", out_valid, 0);
      out_ready = 1'b0;

      // ---- 2: 4-word packet, held then streamed ----
      clear_mon();
      for (int i = 0; i < 4; i++) send_word(32'h0002_0000 + i, i == 3);
      check("t2_no_valid", seen_valid, 0);
      check("t2_used", used_words, 4);
      check("t2_pkt", pkt_count, 1);
      out_ready = 1'b1;
      wait_words(4);
      for (int i = 0; i < 4; i++) begin
         exp_w = {(i == 3) ? 1'b1 : 1'b0, 32'h0002_0000 + i};
         if (i < q_got.size()) check("t2_word", q_got[i], exp_w);
      end
      check("t2_pkt_end", pkt_count, 0);

      // ---- 3: staged words then drop (with a same-cycle write) ----
      clear_mon();
      for (int i = 0; i < 3; i++) send_word(32'h0003_0000 + i, 1'b0);
      check("t3_used_staged", used_words, 3);
      in_drop = 1'b1; in_valid = 1'b1; in_data = DATA_BITS'(32'hDEAD); in_last = 1'b1;
      tick();
      in_drop = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      check("t3_used_drop", used_words, 0);
      check("t3_drop_cnt", drop_cnt, 1);
      check("t3_pkt", pkt_count, 0);
      repeat (2) tick();
      check("t3_no_valid", seen_valid, 0);
      send_word(32'h0004_0000, 1'b0);
      send_word(32'h0004_0001, 1'b1);
      wait_words(2);
      if (q_got.size() >= 2) begin
         check("t3_next_w0", q_got[0], {1'b0, 32'h0004_0000});
         check("t3_next_w1", q_got[1], {1'b1, 32'h0004_0001});
      end

      // ---- 4: 1025-word packet overflows an empty buffer ----
      out_ready = 1'b0;
      clear_mon();
      for (int i = 0; i < 1024; i++) send_word(32'h0007_0000 + i, 1'b0);
      check("t4_used_full", used_words, 1024);
      check("t4_ready_full", in_ready, 0);
      tick();
      check("t4_ovf_pulse", ovf_err, 1);
      check("t4_used_ovf", used_words, 0);
      check("t4_ready_disc", in_ready, 1);
      send_word(32'h0007_0400, 1'b1);
      tick();
      check("t4_ovf_once", ovf_seen, 1);
      check("t4_drop_cnt", drop_cnt, 2);
      check("t4_no_valid", seen_valid, 0);
      check("t4_used_end", used_words, 0);
      check("t4_pkt", pkt_count, 0);

      // ---- 5: 1023 + 4 words with continuous drain across the wrap ----
      clear_mon();
      out_ready = 1'b1;
      for (int i = 0; i < 1023; i++) send_word(32'h0005_0000 + i, i == 1022);
      for (int i = 0; i < 4; i++) send_word(32'h0006_0000 + i, i == 3);
      wait_words(1027);
      check("t5_af_seen", af_seen, 1);
      check("t5_af_used", af_used, 1008);
      bad = 0;
      for (int i = 0; i < q_got.size() && i < 1027; i++) begin
         if (i < 1023) exp_w = {(i == 1022) ? 1'b1 : 1'b0, 32'h0005_0000 + i};
         else          exp_w = {(i == 1026) ? 1'b1 : 1'b0, 32'h0006_0000 + (i - 1023)};
         if (q_got[i] !== exp_w) bad++;
      end
      check("t5_order", bad, 0);
      tick();
      check("t5_used_end", used_words, 0);
      check("t5_pkt_end", pkt_count, 0);
      check("t5_af_end", almost_full, 0);

      // ---- 6: asynchronous reset mid-packet and mid-read ----
      clear_mon();
      out_ready = 1'b0;
      send_word(32'h0008_0000, 1'b0);
      send_word(32'h0008_0001, 1'b1);
      tick();
      check("t6_valid_pre", out_valid, 1);
      send_word(32'h0009_0000, 1'b0);
      in_valid = 1'b1; in_data = DATA_BITS'(32'h0009_0001);
      #2;
      resetn = 1'b0;
      #1;
      in_valid = 1'b0;
      check("t6_rst_valid", out_valid, 0);
      check("t6_rst_used", used_words, 0);
      check("t6_rst_pkt", pkt_count, 0);
      check("t6_rst_drop", drop_cnt, 0);
      check("t6_rst_ready", in_ready, 0);
      check("t6_rst_data", {out_last, out_data}, 0);
      repeat (2) tick();
      resetn = 1'b1;
      tick();
      check("t6_ready", in_ready, 1);
      clear_mon();
      out_ready = 1'b1;
      send_word(32'h000A_0000, 1'b0);
      send_word(32'h000A_0001, 1'b1);
      wait_words(2);
      if (q_got.size() >= 2) begin
         check("t6_w0", q_got[0], {1'b0, 32'h000A_0000});
         check("t6_w1", q_got[1], {1'b1, 32'h000A_0001});
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
